// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer and its return stack.
package pc_sequencer_pkg;

  localparam int unsigned DEFAULT_ADDR_W      = 8;
  localparam int unsigned DEFAULT_STACK_DEPTH = 8;
  localparam int unsigned PC_RESET            = 0;

  typedef enum logic [1:0] {
    SEQ_BOOT = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_TRAP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Pointer-based LIFO of return addresses; the occupancy count doubles as the write pointer.
module return_stack
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_ADDR_W,
  parameter int unsigned DEPTH = DEFAULT_STACK_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CNT_W-1:0] depth_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] depth_q;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] top_idx;

  assign wr_idx  = depth_q[PTR_W-1:0];
  assign top_idx = PTR_W'(depth_q - CNT_W'(1));
  assign full_o  = (depth_q == CNT_W'(DEPTH));
  assign empty_o = (depth_q == '0);
  assign top_o   = mem_q[top_idx];
  assign depth_o = depth_q;

  // Entries are cleared on reset so no return address survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i && !full_o) begin
      mem_q[wr_idx] <= data_i;
      depth_q       <= depth_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      depth_q <= depth_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and call-stack controller driving the instruction ROM address.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
  parameter int unsigned STACK_DEPTH = DEFAULT_STACK_DEPTH,
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH) + 1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStall,
  input  logic               iRet,
  input  logic               iCall,
  input  logic               iJump,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iTarget,
  output logic [ADDR_W-1:0]  oPC,
  output logic               oValid,
  output logic [DEPTH_W-1:0] oDepth,
  output logic               oOverflow,
  output logic               oUnderflow
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push, pop;
  logic [ADDR_W-1:0] stack_top;
  logic              stack_full, stack_empty;

  assign pc_inc = pc_q + ADDR_W'(1);

  return_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (Clock),
    .rst_n   (Reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_inc),
    .top_o   (stack_top),
    .depth_o (oDepth),
    .full_o  (stack_full),
    .empty_o (stack_empty)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= SEQ_BOOT;
      pc_q    <= ADDR_W'(PC_RESET);
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Next-PC mux in strobe priority order; faults freeze the PC on the faulting instruction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      SEQ_BOOT: state_d = SEQ_RUN;
      SEQ_RUN: begin
        if (iStall) begin
          pc_d = pc_q;
        end else if (iRet) begin
          if (stack_empty) begin
            unf_d   = 1'b1;
            state_d = SEQ_TRAP;
          end else begin
            pop  = 1'b1;
            pc_d = stack_top;
          end
        end else if (iCall) begin
          if (stack_full) begin
            ovf_d   = 1'b1;
            state_d = SEQ_TRAP;
          end else begin
            push = 1'b1;
            pc_d = iTarget;
          end
        end else if (iJump || iBranchTaken) begin
          pc_d = iTarget;
        end else begin
          pc_d = pc_inc;
        end
      end
      SEQ_TRAP: state_d = SEQ_TRAP;
      default:  state_d = SEQ_BOOT;
    endcase
    valid_d = (state_d == SEQ_RUN);
  end

  assign oPC        = pc_q;
  assign oValid     = valid_q;
  assign oOverflow  = ovf_q;
  assign oUnderflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed strobe vectors with hand-computed PC/stack results.
module tb_pc_sequencer;

  logic       Clock;
  logic       Reset;
  logic       iStall, iRet, iCall, iJump, iBranchTaken;
  logic [7:0] iTarget;
  logic [7:0] oPC;
  logic       oValid;
  logic [3:0] oDepth;
  logic       oOverflow, oUnderflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] pc;
    logic       v;
    logic [3:0] d;
    logic       o;
    logic       u;
  } exp_t;

  exp_t sb[$];

  pc_sequencer dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iStall       (iStall),
    .iRet         (iRet),
    .iCall        (iCall),
    .iJump        (iJump),
    .iBranchTaken (iBranchTaken),
    .iTarget      (iTarget),
    .oPC          (oPC),
    .oValid       (oValid),
    .oDepth       (oDepth),
    .oOverflow    (oOverflow),
    .oUnderflow   (oUnderflow)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check_out(input exp_t e);
    checks++;
    if (oPC !== e.pc || oValid !== e.v || oDepth !== e.d ||
        oOverflow !== e.o || oUnderflow !== e.u) begin
      errors++;
      $display("FAIL %s: got pc=%0d valid=%b depth=%0d ovf=%b unf=%b, expected pc=%0d valid=%b depth=%0d ovf=%b unf=%b",
               e.tag, oPC, oValid, oDepth, oOverflow, oUnderflow,
               e.pc, e.v, e.d, e.o, e.u);
    end
  endtask

  // Monitor: the sequencer presents a new PC every cycle, so each edge retires one expectation.
  always @(posedge Clock) begin
    #1;
    if (sb.size() > 0) check_out(sb.pop_front());
  end

  task automatic step(input string tag, input logic st, input logic rt, input logic cl,
                      input logic jp, input logic br, input logic [7:0] tg,
                      input logic [7:0] pc, input logic v, input logic [3:0] d,
                      input logic o, input logic u);
    exp_t e;
    @(negedge Clock);
    iStall = st; iRet = rt; iCall = cl; iJump = jp; iBranchTaken = br; iTarget = tg;
    e = '{tag, pc, v, d, o, u};
    sb.push_back(e);
    @(posedge Clock);
  endtask

  task automatic idle(input string tag, input logic [7:0] pc, input logic [3:0] d);
    step(tag, 0, 0, 0, 0, 0, 8'd0, pc, 1'b1, d, 1'b0, 1'b0);
  endtask

  // Asserts reset between edges, checks the asynchronous clear, then releases just after an edge.
  task automatic do_reset(input string tag);
    exp_t e;
    @(negedge Clock);
    Reset = 1'b0;
    iStall = 0; iRet = 0; iCall = 0; iJump = 0; iBranchTaken = 0; iTarget = 8'd0;
    #1;
    e = '{{tag, "_async"}, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    check_out(e);
    e = '{{tag, "_held"}, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    sb.push_back(e);
    @(posedge Clock);
    #2;
    Reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0;
    iStall = 0; iRet = 0; iCall = 0; iJump = 0; iBranchTaken = 0; iTarget = 8'd0;

    do_reset("por");
    idle("boot_first_pc", 8'd0, 4'd0);
    for (int i = 1; i <= 256; i++) idle("count_wrap", 8'(i), 4'd0);
    for (int i = 1; i <= 3; i++) idle("count", 8'(i), 4'd0);

    step("call", 0, 0, 1, 0, 0, 8'd100, 8'd100, 1, 4'd1, 0, 0);
    for (int i = 101; i <= 107; i++) idle("in_sub", 8'(i), 4'd1);
    step("ret", 0, 1, 0, 0, 0, 8'd0, 8'd4, 1, 4'd0, 0, 0);

    for (int i = 5; i <= 12; i++) idle("count2", 8'(i), 4'd0);
    for (int i = 0; i < 5; i++) step("stall_jump", 1, 0, 0, 1, 0, 8'd19, 8'd12, 1, 4'd0, 0, 0);
    step("stall_release", 0, 0, 0, 1, 0, 8'd19, 8'd19, 1, 4'd0, 0, 0);

    step("call_beats_jump", 0, 0, 1, 1, 0, 8'd50, 8'd50, 1, 4'd1, 0, 0);
    step("ret_beats_call", 0, 1, 1, 0, 0, 8'd70, 8'd20, 1, 4'd0, 0, 0);
    step("branch", 0, 0, 0, 0, 1, 8'd30, 8'd30, 1, 4'd0, 0, 0);

    step("nest1", 0, 0, 1, 0, 0, 8'd40, 8'd40, 1, 4'd1, 0, 0);
    step("nest2", 0, 0, 1, 0, 0, 8'd60, 8'd60, 1, 4'd2, 0, 0);
    step("unwind2", 0, 1, 0, 0, 0, 8'd0, 8'd41, 1, 4'd1, 0, 0);
    step("unwind1", 0, 1, 0, 0, 0, 8'd0, 8'd31, 1, 4'd0, 0, 0);

    for (int k = 1; k <= 8; k++) step("deep_call", 0, 0, 1, 0, 0, 8'd40, 8'd40, 1, 4'(k), 0, 0);
    step("overflow", 0, 0, 1, 0, 0, 8'd40, 8'd40, 0, 4'd8, 1, 0);
    step("trap_ign_jump", 0, 0, 0, 1, 0, 8'd5, 8'd40, 0, 4'd8, 1, 0);
    step("trap_ign_ret", 0, 1, 0, 0, 0, 8'd0, 8'd40, 0, 4'd8, 1, 0);

    do_reset("ovf_reset");
    idle("boot_after_ovf", 8'd0, 4'd0);
    for (int i = 1; i <= 20; i++) idle("count3", 8'(i), 4'd0);
    step("underflow", 0, 1, 0, 0, 0, 8'd0, 8'd20, 0, 4'd0, 0, 1);
    step("trap_ign_call", 0, 0, 1, 0, 0, 8'd9, 8'd20, 0, 4'd0, 0, 1);

    do_reset("unf_reset");
    idle("boot_after_unf", 8'd0, 4'd0);
    idle("count4", 8'd1, 4'd0);

    for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge Clock);
    #2;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and call-stack controller that sequences the instruction ROM of the lab CPU. It drives the ROM address every cycle and advances, jumps, calls or returns based on flow-control strobes from the instruction decoder. It holds the address during execution stalls (keyboard wait, VGA busy) and traps on return-stack faults. It sits between the decoder/execute stage and the ROM `iAddress` input.

## Interface
- `ADDR_W`, 8: program-counter and ROM address width.
- `STACK_DEPTH`, 8: number of return-address entries; must be a power of two, at least 2.
- `Clock` in 1: rising-edge system clock.
- `Reset` in 1: asynchronous, active-low reset.
- `iStall` in 1: hold the current instruction; highest priority after reset and trap.
- `iRet` in 1: the instruction at `oPC` is RET.
- `iCall` in 1: the instruction at `oPC` is CALL to `iTarget`.
- `iJump` in 1: unconditional JMP to `iTarget`.
- `iBranchTaken` in 1: conditional branch (BEQ/BLE) resolved taken, go to `iTarget`.
- `iTarget` in ADDR_W: jump, call or branch destination.
- `oPC` out ADDR_W: ROM address; the instruction at this address is the current one.
- `oValid` out 1: current instruction is executable; the decoder must ignore the instruction while this is 0.
- `oDepth` out log2(STACK_DEPTH)+1: number of occupied stack entries.
- `oOverflow` out 1: sticky; a CALL was issued with the stack full.
- `oUnderflow` out 1: sticky; a RET was issued with the stack empty.

## Operation
- FSM states:
  - BOOT: entered on reset. `oValid`=0.
  - RUN: `oValid`=1.
  - TRAP: `oValid`=0.
- Transitions:
  - BOOT→RUN unconditionally on the first clock edge after `Reset` deasserts.
  - RUN→TRAP on a stack fault.
  - TRAP is left only by reset.
- Next-PC rule in RUN, evaluated in priority order:
  1. `iStall`: PC and stack unchanged, regardless of the other strobes.
  2. `iRet`: PC ← top of stack; pop.
  3. `iCall`: push PC+1; PC ← `iTarget`.
  4. `iJump` or `iBranchTaken`: PC ← `iTarget`.
  5. Otherwise: PC ← PC+1.
- Arithmetic: PC+1 is modulo 2^ADDR_W, so 255→0 at the default width. The pushed return address wraps the same way.
- Fault handling:
  - CALL when `oDepth`=STACK_DEPTH: no push, PC unchanged, `oOverflow`←1, go to TRAP.
  - RET when `oDepth`=0: no pop, PC unchanged, `oUnderflow`←1, go to TRAP.
  - In both cases `oPC` keeps the faulting instruction's address for debug.
- Strobes are ignored in BOOT and TRAP.
- Simultaneous strobes resolve by the priority list above; the losers have no effect.
- Nested subroutines, e.g. Read calling Sleep, are legal up to STACK_DEPTH levels.

## Timing
- Reset values: `oPC`=0, `oValid`=0, `oDepth`=0, `oOverflow`=0, `oUnderflow`=0, state BOOT. All stack entries read as 0.
- ROM and decoder are combinational. Strobes are valid in the same cycle as `oPC` and are sampled on the rising edge.
- Latency: one instruction per cycle. `oPC` updates on the same edge that samples the strobes, so there is no delay slot.
- The first executed instruction is address 0, in the cycle after BOOT. The bubble is exactly one cycle.
- `oDepth` updates on the edge of the push or pop. CALL followed immediately by RET returns to the caller's PC+1 with no extra cycle.
- Asserting `Reset` mid-stall or mid-subroutine clears everything immediately (asynchronously). No return address survives reset.

## Structure
- Add to the shared definitions header:
  - FSM state encodings `SEQ_BOOT`, `SEQ_RUN`, `SEQ_TRAP`.
  - Reset PC constant `PC_RESET` = 0.
  - Default `STACK_DEPTH`.
- One sub-module, `return_stack`:
  - LIFO of STACK_DEPTH × ADDR_W.
  - Ports: push, pop, data in, top out, depth, full, empty.
  - Pointer-based, with registered entries.
  - Push and pop in the same cycle never occurs; the sequencer's priority order guarantees this.
- `pc_sequencer` contains the FSM, PC register, next-PC mux and sticky flags.

## Test plan
- Reset release, no strobes: `oValid` stays 0 for 1 cycle, then `oPC` steps 0,1,2,… and wraps 255→0.
- At PC=3 assert `iCall` with `iTarget`=100, then `iRet` at PC=107: PC goes 100; `oDepth`=1; after RET, PC=4 and `oDepth`=0.
- `iStall` held 5 cycles with `iJump`=1 and `iTarget`=19 at PC=12: PC stays 12 for all 5 cycles; after release, PC=19.
- `iCall` and `iJump` together, then `iRet` and `iCall` together: the CALL wins in the first case and the RET wins in the second; `oDepth` goes 1 then 0.
- 8 nested calls, then a 9th at PC=40: `oOverflow`=1, `oValid`=0, `oPC`=40 frozen, `oDepth`=8. Strobes are ignored until `Reset`.
- RET with an empty stack at PC=20: `oUnderflow`=1, TRAP, `oPC` frozen at 20. Asserting `Reset` mid-trap returns all outputs to their reset values.
